piso_stream_buffer: RTL and testbench

Parallel-in, serial-out buffer with valid/ready handshakes on both sides. It accepts a DEPTH-word parallel block and streams out a programmable number of WIDTH-bit words, with selectable word order and frame-end signalling. It sits between the Keccak permutation state and the output stream during squeeze. It truncates the final rate block to the requested output length and can accept the next block on the cycle the last word leaves, so back-to-back blocks stream without a bubble.

---
 rtl/piso_stream_buffer.sv | 100 ++++++++++
 tb/tb_piso_stream_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piso_stream_buffer.sv
// Parallel-in, serial-out word buffer with valid/ready on both sides.
// Truncates each block to a programmable count and reloads on the last-word cycle.
module piso_stream_buffer #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 17,
  parameter bit          MSW_FIRST = 1'b1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH*WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]       in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   flush,
  output logic                   busy
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             out_valid_q, out_last_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q [DEPTH-1];
  logic [WIDTH-1:0] tail_d [DEPTH-1];
  logic [WIDTH-1:0] ordered [DEPTH];
  logic [CNT_W-1:0] eff_cnt;
  logic             load;
  logic             fire;

  assign in_ready  = rst_n && !flush &&
                     ((rem_q == '0) || ((rem_q == CNT_W'(1)) && out_ready));
  assign load      = in_valid && in_ready;
  assign fire      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = head_q;
  assign busy      = out_valid_q;

  // Reorder the incoming block so that index 0 is the first word to leave.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (MSW_FIRST) ordered[i] = in_data[(int'(DEPTH) - i)*int'(WIDTH) - 1 -: WIDTH];
      else           ordered[i] = in_data[(i + 1)*int'(WIDTH) - 1 -: WIDTH];
    end
  end

  // Zero or oversized counts mean a full block.
  always_comb begin
    eff_cnt = in_count;
    if ((in_count == '0) || (in_count > CNT_W'(DEPTH))) eff_cnt = CNT_W'(DEPTH);
  end

  // Next state: flush beats load, load beats the output shift.
  always_comb begin
    rem_d  = rem_q;
    last_d = last_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      rem_d  = '0;
      last_d = 1'b0;
    end else if (load) begin
      rem_d  = eff_cnt;
      last_d = in_last;
      head_d = ordered[0];
      for (int i = 0; i < int'(DEPTH) - 1; i++) tail_d[i] = ordered[i + 1];
    end else if (fire) begin
      rem_d  = rem_q - CNT_W'(1);
      head_d = tail_q[0];
      for (int i = 0; i < int'(DEPTH) - 2; i++) tail_d[i] = tail_q[i + 1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      last_q      <= 1'b0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      last_q      <= last_d;
      head_q      <= head_d;
      out_valid_q <= (rem_d != '0);
      out_last_q  <= last_d && (rem_d == CNT_W'(1));
    end
  end

  // Word storage behind the head carries no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

endmodule

// File: tb/tb_piso_stream_buffer.sv
// Directed bench for piso_stream_buffer at WIDTH=8, DEPTH=4, both word orders.
module tb_piso_stream_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [DEPTH*WIDTH-1:0] in_data;
  logic [CNT_W-1:0]       in_count;
  logic                   in_last;
  logic                   out_ready;
  logic                   flush;

  logic             m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [WIDTH-1:0] m_out_data;
  logic             l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [WIDTH-1:0] l_out_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSW_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_count(in_count), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_last(m_out_last), .flush(flush), .busy(m_busy)
  );

  piso_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSW_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_count(in_count), .in_last(in_last),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .out_last(l_out_last), .flush(flush), .busy(l_busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
    logic        last;
    int          n;
    logic [31:0] exp;
    logic        exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w;
    return t[31 - 8*k -: 8];
  endfunction

  // Offer a block on the next edge; returns at the negedge where its first word shows.
  task automatic load_block(input logic [31:0] d, input logic [2:0] c, input logic l);
    chk("in_ready_idle", 32'(m_in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_count = c;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hAABBCCDD, 3'd4, 1'b1, 4, 32'hAABBCCDD, 1'b1};
    vecs[1] = '{32'hAABBCCDD, 3'd2, 1'b0, 2, 32'hAABB0000, 1'b0};
    vecs[2] = '{32'hAABBCCDD, 3'd0, 1'b0, 4, 32'hAABBCCDD, 1'b0};
    vecs[3] = '{32'hAABBCCDD, 3'd7, 1'b1, 4, 32'hAABBCCDD, 1'b1};
    vecs[4] = '{32'hAABBCCDD, 3'd1, 1'b1, 1, 32'hAA000000, 1'b1};
    vecs[5] = '{32'h11223344, 3'd3, 1'b1, 3, 32'h11223300, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0;
    in_last = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #12;
    chk("rst_valid", 32'(m_out_valid), 32'd0);
    chk("rst_last",  32'(m_out_last),  32'd0);
    chk("rst_data",  32'(m_out_data),  32'd0);
    chk("rst_busy",  32'(m_busy),      32'd0);
    chk("rst_ready", 32'(m_in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", 32'(m_out_valid), 32'd0);

    // Table: load, drain with out_ready held high, confirm the buffer empties.
    foreach (vecs[v]) begin
      load_block(vecs[v].data, vecs[v].count, vecs[v].last);
      for (int k = 0; k < vecs[v].n; k++) begin
        chk($sformatf("v%0d_valid%0d", v, k), 32'(m_out_valid), 32'd1);
        chk($sformatf("v%0d_data%0d", v, k), 32'(m_out_data), 32'(word_of(vecs[v].exp, k)));
        chk($sformatf("v%0d_last%0d", v, k), 32'(m_out_last),
            32'((k == vecs[v].n - 1) && vecs[v].exp_last));
        @(negedge clk);
      end
      chk($sformatf("v%0d_empty", v), 32'(m_out_valid), 32'd0);
      chk($sformatf("v%0d_busy", v), 32'(m_busy), 32'd0);
    end

    // Backpressure while BB is presented.
    load_block(32'hAABBCCDD, 3'd4, 1'b1);
    chk("bp_aa", 32'(m_out_data), 32'hAA);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), 32'(m_out_data), 32'hBB);
      chk($sformatf("bp_valid%0d", k), 32'(m_out_valid), 32'd1);
      chk($sformatf("bp_inrdy%0d", k), 32'(m_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_cc", 32'(m_out_data), 32'hCC);
    @(negedge clk);
    chk("bp_dd", 32'(m_out_data), 32'hDD);
    chk("bp_dd_last", 32'(m_out_last), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(m_out_valid), 32'd0);

    // Back-to-back: second block held on the input until it is taken.
    load_block(32'hAABBCCDD, 3'd4, 1'b0);
    in_valid = 1'b1; in_data = 32'h11223344; in_count = 3'd4; in_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] seq;
      seq = 64'hAABBCCDD11223344;
      if (k == 4) in_valid = 1'b0;
      chk($sformatf("b2b_valid%0d", k), 32'(m_out_valid), 32'd1);
      chk($sformatf("b2b_data%0d", k), 32'(m_out_data), 32'(seq[63 - 8*k -: 8]));
      chk($sformatf("b2b_last%0d", k), 32'(m_out_last), 32'(k == 7));
      if (k < 4) chk($sformatf("b2b_inrdy%0d", k), 32'(m_in_ready), 32'(k == 3));
      @(negedge clk);
    end
    chk("b2b_empty", 32'(m_out_valid), 32'd0);

    // Flush while BB is presented, with a competing load.
    load_block(32'hAABBCCDD, 3'd4, 1'b1);
    @(negedge clk);
    chk("fl_bb", 32'(m_out_data), 32'hBB);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h11223344; in_count = 3'd4;
    #1 chk("fl_inrdy", 32'(m_in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(m_out_valid), 32'd0);
    chk("fl_last",  32'(m_out_last),  32'd0);
    chk("fl_busy",  32'(m_busy),      32'd0);
    @(negedge clk);
    chk("fl_refused", 32'(m_out_valid), 32'd0);

    // Asynchronous reset mid-drain.
    load_block(32'hAABBCCDD, 3'd4, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(m_out_valid), 32'd0);
    chk("ar_data",  32'(m_out_data),  32'd0);
    chk("ar_busy",  32'(m_busy),      32'd0);
    chk("ar_inrdy", 32'(m_in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar_stale%0d", k), 32'(m_out_valid), 32'd0);
    end

    // Least-significant-word-first instance.
    chk("lsw_inrdy", 32'(l_in_ready), 32'd1);
    load_block(32'hAABBCCDD, 3'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic [23:0] lexp;
      lexp = 24'hDDCCBB;
      chk($sformatf("lsw_valid%0d", k), 32'(l_out_valid), 32'd1);
      chk($sformatf("lsw_data%0d", k), 32'(l_out_data), 32'(lexp[23 - 8*k -: 8]));
      chk($sformatf("lsw_last%0d", k), 32'(l_out_last), 32'(k == 2));
      @(negedge clk);
    end
    chk("lsw_empty", 32'(l_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
